// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Memory-access / writeback end of the pipeline. Takes the EXE-stage result,
// performs loads and stores against an internal word memory and registers the
// MEM/WB result that drives the register-file write port.
//
// A load takes two cycles. In the issue cycle mem_stall holds the upstream
// pipeline, the read address is registered and a bubble is written back. In
// the following cycle (LOAD) the read data is captured. Stores complete in the
// same edge as the MEM/WB capture and never write back.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : loads/stores with ALU_Res_IN[1:0] != 0 are suppressed (store
//               dropped, load becomes a non-stalling bubble) and the sticky
//               misalign_err flag is set until rst.
//   undefined : the low two address bits are ignored; misalign_err is 0.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   WB_EN_IN       instruction writes a register
//   MEM_R_EN_IN    load
//   MEM_W_EN_IN    store (wins when both enables are set)
//   ALU_Res_IN     ALU result / byte address
//   Val_Rm_IN      store data
//   Dest_IN        destination register
//   writeBackEn    registered register-file write enable
//   Dest_wb        registered destination register
//   Result_WB      registered writeback data
//   mem_stall      combinational upstream hold (Mealy: state + MEM_R_EN_IN)
//   misalign_err   sticky misaligned-access flag
//   o_dbg_state    current FSM state (0 = IDLE, 1 = LOAD)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_BASE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic [31:0] ALU_Res_IN,
    input  logic [31:0] Val_Rm_IN,
    input  logic [3:0]  Dest_IN,
    output logic        writeBackEn,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_WB,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic        o_dbg_state
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOAD = 1'b1;

    logic          r_state;
    logic [AW-1:0] r_raddr;
    logic          r_wb_en;
    logic [3:0]    r_dest;
    logic [31:0]   r_result;
    logic [31:0]   r_mem [MEM_WORDS];

    logic [31:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic          w_misalign;
    logic          w_load_req;
    logic          w_load_issue;
    logic          w_store_do;

    // Word index wraps modulo MEM_WORDS by truncation of the shifted offset.
    assign w_offset = ALU_Res_IN - 32'(ADDR_BASE);
    assign w_idx    = AW'(w_offset >> 2);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = (MEM_R_EN_IN | MEM_W_EN_IN) & (ALU_Res_IN[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // A simultaneous store enable turns a load into a plain store.
    assign w_load_req   = MEM_R_EN_IN & ~MEM_W_EN_IN;
    assign w_load_issue = (r_state == ST_IDLE) & w_load_req & ~w_misalign;
    assign w_store_do   = (r_state == ST_IDLE) & MEM_W_EN_IN & ~w_misalign;

    // In LOAD the upstream inputs still present the load, so no stall there;
    // that is what keeps the load from being re-issued.
    assign mem_stall = w_load_issue & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_raddr  <= '0;
            r_wb_en  <= 1'b0;
            r_dest   <= 4'd0;
            r_result <= 32'd0;
        end else if (r_state == ST_LOAD) begin
            r_wb_en  <= WB_EN_IN;
            r_dest   <= Dest_IN;
            r_result <= r_mem[r_raddr];
            r_state  <= ST_IDLE;
        end else begin
            // Loads (issued or trapped) and stores both write back a bubble.
            r_wb_en  <= WB_EN_IN & ~MEM_W_EN_IN & ~w_load_req;
            r_dest   <= Dest_IN;
            r_result <= ALU_Res_IN;
            if (w_load_issue) begin
                r_raddr <= w_idx;
                r_state <= ST_LOAD;
            end
        end
    end

    // Memory contents survive reset; only the write itself is blocked in rst.
    always_ff @(posedge clk) begin
        if (!rst && w_store_do) begin
            r_mem[w_idx] <= Val_Rm_IN;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_misalign) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`else
    assign misalign_err = 1'b0;
`endif

    assign writeBackEn = r_wb_en;
    assign Dest_wb     = r_dest;
    assign Result_WB   = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Drives instruction-level stimulus into mem_wb_stage. Each issued
// instruction is turned into per-cycle expectations by a word-array memory
// model; a single compare process checks mem_stall, writeBackEn, Dest_wb,
// Result_WB and misalign_err every cycle. Directed literal checks pin the
// model on the scenarios of the test plan.
//
// Valid/ready note: there is no ready input; mem_stall is the only back
// pressure. When mem_stall is high in a cycle, the upstream inputs are held
// unchanged for the next cycle, which is what the driver does for loads.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int EW = 39;  // {err, chk_full, wb, dest[3:0], result[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wb_en_in = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] alu_res = 32'd0;
  logic [31:0] val_rm = 32'd0;
  logic [3:0]  dest_in = 4'd0;

  logic        write_back_en;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
  logic        mem_stall;
  logic        misalign_err;
  logic        dbg_state;

  mem_wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .WB_EN_IN    (wb_en_in),
    .MEM_R_EN_IN (mem_r_en),
    .MEM_W_EN_IN (mem_w_en),
    .ALU_Res_IN  (alu_res),
    .Val_Rm_IN   (val_rm),
    .Dest_IN     (dest_in),
    .writeBackEn (write_back_en),
    .Dest_wb     (dest_wb),
    .Result_WB   (result_wb),
    .mem_stall   (mem_stall),
    .misalign_err(misalign_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- model / scoreboard state ----------------
  logic [31:0]   model_mem [64];
  bit            model_valid [64];
  logic          model_err = 1'b0;
  logic          exp_stall = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] pend;
  bit            pend_v = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit is_misaligned(input logic r, input logic w, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    return (r || w) && (addr % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("mem_stall", {31'd0, mem_stall}, {31'd0, exp_stall});
      if (pend_v) begin
        check("writeBackEn", {31'd0, write_back_en}, {31'd0, pend[36]});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, pend[38]});
        if (pend[37]) begin
          check("Dest_wb", {28'd0, dest_wb}, {28'd0, pend[35:32]});
          check("Result_WB", result_wb, pend[31:0]);
        end
      end
      if (exp_q.size() > 0) begin
        pend   = exp_q.pop_front();
        pend_v = 1'b1;
      end else begin
        pend_v = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction; a load that is not trapped holds its inputs for two cycles.
  task automatic issue(input logic wb, input logic r, input logic w,
                       input logic [31:0] addr, input logic [31:0] val,
                       input logic [3:0] dest);
    int unsigned idx;
    bit mis;
    bit is_load;
    idx     = ((addr - 32'd1024) / 4) % 64;
    mis     = is_misaligned(r, w, addr);
    is_load = r && !w;
    wb_en_in = wb; mem_r_en = r; mem_w_en = w;
    alu_res  = addr; val_rm = val; dest_in = dest;
    if (mis) model_err = 1'b1;
    if (is_load && !mis) begin
      exp_stall = 1'b1;
      exp_q.push_back({model_err, 1'b0, 1'b0, dest, addr});
      tick();
      exp_stall = 1'b0;
      exp_q.push_back({model_err, model_valid[idx], wb, dest, model_mem[idx]});
      tick();
    end else begin
      exp_stall = 1'b0;
      if (w && !mis) begin
        model_mem[idx]   = val;
        model_valid[idx] = 1'b1;
      end
      exp_q.push_back({model_err, !(r || w), wb && !r && !w, dest, addr});
      tick();
    end
  endtask

  task automatic idle_cycle();
    issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  // Asserts rst (inputs untouched for the first check), verifies the reset
  // state, then releases it with idle inputs.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_mem_stall"}, {31'd0, mem_stall}, 32'd0);
    check({tag, "_writeBackEn"}, {31'd0, write_back_en}, 32'd0);
    check({tag, "_Dest_wb"}, {28'd0, dest_wb}, 32'd0);
    check({tag, "_Result_WB"}, result_wb, 32'd0);
    check({tag, "_misalign_err"}, {31'd0, misalign_err}, 32'd0);
    check({tag, "_state_idle"}, {31'd0, dbg_state}, 32'd0);
    wb_en_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    alu_res = 32'd0; val_rm = 32'd0; dest_in = 4'd0;
    exp_q.delete();
    pend_v    = 1'b0;
    model_err = 1'b0;
    exp_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int op;
    logic [31:0] addr;
    for (int i = 0; i < 64; i++) begin
      model_mem[i]   = 32'd0;
      model_valid[i] = 1'b0;
    end

    do_reset("reset");

    // ALU op: result next cycle, never a stall.
    issue(1'b1, 1'b0, 1'b0, 32'h0000_002A, 32'd0, 4'd3);
    check("alu_wb_en", {31'd0, write_back_en}, 32'd1);
    check("alu_dest", {28'd0, dest_wb}, 32'd3);
    check("alu_result", result_wb, 32'h0000_002A);

    // Store then load of the same word.
    issue(1'b1, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd7);
    check("store_wb_en", {31'd0, write_back_en}, 32'd0);
    issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd5);
    check("load_result", result_wb, 32'hDEAD_BEEF);
    check("load_dest", {28'd0, dest_wb}, 32'd5);

    // Address wrap: 1280 aliases word 0.
    issue(1'b0, 1'b0, 1'b1, 32'd1280, 32'h0000_1234, 4'd0);
    issue(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd1);
    check("wrap_result", result_wb, 32'h0000_1234);

    // Back-to-back loads.
    issue(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd1);
    check("b2b_first", result_wb, 32'h0000_1234);
    issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd2);
    check("b2b_second", result_wb, 32'hDEAD_BEEF);

    // Load together with store behaves as a store only.
    issue(1'b1, 1'b1, 1'b1, 32'd1032, 32'h5555_AAAA, 4'd4);
    issue(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd4);
    check("ld_st_store", result_wb, 32'h5555_AAAA);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned store is dropped and the error flag sticks.
    issue(1'b0, 1'b0, 1'b1, 32'd1025, 32'hFFFF_FFFF, 4'd0);
    check("mis_err_set", {31'd0, misalign_err}, 32'd1);
    issue(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd6);
    check("mis_word0", result_wb, 32'h0000_1234);
    check("mis_err_sticky", {31'd0, misalign_err}, 32'd1);
    issue(1'b1, 1'b1, 1'b0, 32'd1027, 32'd0, 4'd6);
    check("mis_load_bubble", {31'd0, write_back_en}, 32'd0);
`endif

    // Reset in the cycle after a load issues: load is abandoned.
    wb_en_in = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0;
    alu_res = 32'd1028; val_rm = 32'd0; dest_in = 4'd9;
    exp_stall = 1'b1;
    exp_q.push_back({model_err, 1'b0, 1'b0, 4'd9, 32'd1028});
    tick();
    do_reset("midload");
    repeat (3) idle_cycle();

    // Fill memory so every random load has a known value.
    for (int i = 0; i < 64; i++) begin
      issue(1'b0, 1'b0, 1'b1, 32'd1024 + 32'(i * 4), $urandom, 4'd0);
    end

    // Randomized instruction mix.
    for (int n = 0; n < 400; n++) begin
      op   = $urandom_range(0, 3);
      addr = 32'($urandom_range(0, 1023)) * 4;
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      case (op)
        0: issue(1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
        1: issue(1'($urandom), 1'b0, 1'b1, addr, $urandom, 4'($urandom));
        2: issue(1'($urandom), 1'b1, 1'b0, addr, $urandom, 4'($urandom));
        default: issue(1'($urandom), 1'b1, 1'b1, addr, $urandom, 4'($urandom));
      endcase
    end
    repeat (3) idle_cycle();

    do_reset("final");
    repeat (2) idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
